// File: rtl/i2c_clk_pkg.sv
// Shared types and constants for the I2C SCL timing generator.
// Phase encoding follows the order in which SCL walks through a period.
package i2c_clk_pkg;

  typedef enum logic [1:0] {
    PH_LOW_A  = 2'd0,
    PH_LOW_B  = 2'd1,
    PH_HIGH_A = 2'd2,
    PH_HIGH_B = 2'd3
  } ph_t;

  localparam int          Q_MIN     = 1;
  localparam logic [15:0] DEFAULT_Q = 16'd125;

endpackage

// File: rtl/i2c_scl_clk_gen.sv
// I2C SCL timing base: programmable quarter-period, phase strobes,
// start/stop at period boundaries and slave clock-stretch hold.
module i2c_scl_clk_gen #(
  parameter int             Q_W       = 16,
  parameter logic [Q_W-1:0] DEFAULT_Q = Q_W'(i2c_clk_pkg::DEFAULT_Q)
) (
  input  logic           clock_in,
  input  logic           reset_n,
  input  logic           enable,
  input  logic           div_load,
  input  logic [Q_W-1:0] div_value,
  input  logic           stretch,
  output logic           clk_out,
  output logic           tick_fall,
  output logic           tick_low_mid,
  output logic           tick_rise,
  output logic           tick_high_mid,
  output logic           running,
  output logic           div_pending
);

  import i2c_clk_pkg::*;

  ph_t            r_phase;
  logic [Q_W-1:0] r_cnt;
  logic [Q_W-1:0] r_q_active;
  logic [Q_W-1:0] r_q_pend;
  logic           r_running;
  logic           r_pending;
  logic           r_clk;
  logic [3:0]     r_tick;

  ph_t            w_phase_n;
  logic [Q_W-1:0] w_cnt_n;
  logic [Q_W-1:0] w_q_active_n;
  logic [Q_W-1:0] w_q_pend_n;
  logic           w_running_n;
  logic           w_pending_n;
  logic           w_clk_n;
  logic [3:0]     w_tick_n;

  logic [Q_W-1:0] w_q_load;
  logic [1:0]     w_ph_inc;
  logic           w_end;
  logic           w_frz;
  logic           w_wrap;

  assign w_q_load = (div_value < Q_W'(Q_MIN)) ? Q_W'(Q_MIN) : div_value;
  assign w_ph_inc = r_phase + 2'd1;
  assign w_end    = (r_cnt == r_q_active - Q_W'(1));
  // High time only counts once the slave has let the line rise.
  assign w_frz    = (r_phase == PH_HIGH_A) && stretch;
  assign w_wrap   = r_running && !w_frz && w_end
                  && (r_phase == PH_HIGH_B);

  always_comb begin
    w_phase_n    = r_phase;
    w_cnt_n      = r_cnt;
    w_q_active_n = r_q_active;
    w_q_pend_n   = r_q_pend;
    w_running_n  = r_running;
    w_pending_n  = r_pending;
    w_tick_n     = 4'b0000;

    if (!r_running) begin
      if (div_load) begin
        w_q_pend_n  = w_q_load;
        w_pending_n = 1'b1;
      end else if (r_pending) begin
        w_q_active_n = r_q_pend;
        w_pending_n  = 1'b0;
      end
      if (enable) begin
        w_running_n = 1'b1;
        w_phase_n   = PH_LOW_A;
        w_cnt_n     = '0;
      end
    end else begin
      if (div_load) begin
        w_q_pend_n  = w_q_load;
        w_pending_n = 1'b1;
      end
      if (!w_frz) begin
        if (w_end) begin
          w_cnt_n   = '0;
          w_phase_n = ph_t'(w_ph_inc);
          unique case (w_phase_n)
            PH_LOW_A:  w_tick_n[0] = 1'b1;
            PH_LOW_B:  w_tick_n[1] = 1'b1;
            PH_HIGH_A: w_tick_n[2] = 1'b1;
            PH_HIGH_B: w_tick_n[3] = 1'b1;
          endcase
        end else begin
          w_cnt_n = r_cnt + Q_W'(1);
        end
      end
      // Divisor swaps and stop requests only land on a period boundary.
      if (w_wrap) begin
        w_running_n = enable;
        if (div_load) begin
          w_q_active_n = w_q_load;
          w_pending_n  = 1'b0;
        end else if (r_pending) begin
          w_q_active_n = r_q_pend;
          w_pending_n  = 1'b0;
        end
      end
    end

    w_clk_n = w_running_n
            && ((w_phase_n == PH_HIGH_A) || (w_phase_n == PH_HIGH_B));
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_phase    <= PH_LOW_A;
      r_cnt      <= '0;
      r_q_active <= DEFAULT_Q;
      r_q_pend   <= DEFAULT_Q;
      r_running  <= 1'b0;
      r_pending  <= 1'b0;
      r_clk      <= 1'b0;
      r_tick     <= 4'b0000;
    end else begin
      r_phase    <= w_phase_n;
      r_cnt      <= w_cnt_n;
      r_q_active <= w_q_active_n;
      r_q_pend   <= w_q_pend_n;
      r_running  <= w_running_n;
      r_pending  <= w_pending_n;
      r_clk      <= w_clk_n;
      r_tick     <= w_tick_n;
    end
  end

  assign clk_out       = r_clk;
  assign tick_fall     = r_tick[0];
  assign tick_low_mid  = r_tick[1];
  assign tick_rise     = r_tick[2];
  assign tick_high_mid = r_tick[3];
  assign running       = r_running;
  assign div_pending   = r_pending;

endmodule
